// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - collects two 4x4 operand matrices from an element stream and issues one ALU op
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake, cmd_op carries the ALU opcode
//   in_valid/in_ready    element handshake, in_data is one 16-bit element, row-major
//   matrix_a, matrix_b   operands, element (i,j) at bits (i*4+j)*16 +: 16
//   op                   opcode to the ALU, NOP except while issuing
//   busy, done           busy outside IDLE, done is a one-cycle completion pulse
module matrix_loader #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [3:0]   cmd_op,
  output logic         cmd_ready,
  input  logic         in_valid,
  input  logic [15:0]  in_data,
  output logic         in_ready,
  output logic [255:0] matrix_a,
  output logic [255:0] matrix_b,
  output logic [3:0]   op,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ISSUE,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MTRANS = 4'h5;
  localparam logic [3:0] LAT       = 4'(ALU_LAT);

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     op_lat_q, op_lat_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [255:0]   mat_a_q, mat_a_d;
  logic [255:0]   mat_b_q, mat_b_d;

  // Bit offset of element idx inside a packed matrix.
  logic [7:0]     elem_lsb;
  assign elem_lsb = {idx_q, 4'b0000};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_lat_d = op_lat_q;
    cnt_d    = cnt_q;
    mat_a_d  = mat_a_q;
    mat_b_d  = mat_b_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_lat_d = cmd_op;
          idx_d    = 4'd0;
          mat_a_d  = '0;
          mat_b_d  = '0;
          state_d  = (cmd_op == OP_NOP) ? S_DONE : S_LOAD_A;
        end
      end

      S_LOAD_A: begin
        if (in_valid) begin
          mat_a_d[elem_lsb +: 16] = in_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            // A transpose has a single operand, so B stays cleared.
            if (op_lat_q == OP_MTRANS) begin
              state_d = S_ISSUE;
              cnt_d   = LAT;
            end else begin
              state_d = S_LOAD_B;
            end
          end
        end
      end

      S_LOAD_B: begin
        if (in_valid) begin
          mat_b_d[elem_lsb +: 16] = in_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = S_ISSUE;
            cnt_d   = LAT;
          end
        end
      end

      S_ISSUE: begin
        // cnt_q holds the number of issue cycles still to present, this one included.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      op_lat_q <= 4'd0;
      cnt_q    <= 4'd0;
      mat_a_q  <= '0;
      mat_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_lat_q <= op_lat_d;
      cnt_q    <= cnt_d;
      mat_a_q  <= mat_a_d;
      mat_b_q  <= mat_b_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign op        = (state_q == S_ISSUE) ? op_lat_q : OP_NOP;
  assign matrix_a  = mat_a_q;
  assign matrix_b  = mat_b_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed table-driven bench for matrix_loader (ALU_LAT 1 and 3 instances)
module tb_matrix_loader;

  logic         clk;
  logic         rst;
  logic [1:0]   cmd_valid;
  logic [3:0]   cmd_op;
  logic [1:0]   in_valid;
  logic [15:0]  in_data;
  logic [1:0]   cr, ir, bz, dn;
  logic [3:0]   op_w [2];
  logic [255:0] ma_w [2];
  logic [255:0] mb_w [2];

  int errors = 0;
  int checks = 0;

  matrix_loader #(.ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_op(cmd_op), .cmd_ready(cr[0]),
    .in_valid(in_valid[0]), .in_data(in_data), .in_ready(ir[0]),
    .matrix_a(ma_w[0]), .matrix_b(mb_w[0]), .op(op_w[0]),
    .busy(bz[0]), .done(dn[0])
  );

  matrix_loader #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_op(cmd_op), .cmd_ready(cr[1]),
    .in_valid(in_valid[1]), .in_data(in_data), .in_ready(ir[1]),
    .matrix_a(ma_w[1]), .matrix_b(mb_w[1]), .op(op_w[1]),
    .busy(bz[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  cop;
    int          sel;
    int          gap;
    int          n;
    logic [15:0] a_base;
    bit          a_col;
    logic [15:0] b_base;
    bit          b_col;
    int          exp_load;
    logic [15:0] exp_a0;
    logic [15:0] exp_a3;
    logic [15:0] exp_a15;
    logic [15:0] exp_b0;
    logic [15:0] exp_b15;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] gen(input logic [15:0] base, input bit col, input int k);
    return col ? base + 16'(k % 4) : base + 16'(k);
  endfunction

  task automatic run_vec(input vec_t v, input int vi);
    int lat, exp_opc, done_at, idle_at;
    int loads, acc, guard;
    int opc, op_bad, dcnt, done_p, unstable, cr_bad;
    logic [255:0] exp_a, exp_b;
    string tag;
    tag = $sformatf("v%0d", vi);
    lat     = (v.sel == 1) ? 3 : 1;
    exp_opc = (v.cop == 4'h0) ? 0 : lat;
    done_at = exp_opc + 1;
    idle_at = done_at + 1;
    exp_a = '0;
    exp_b = '0;
    for (int k = 0; k < 16; k++) begin
      if (v.n > 0)  exp_a[k*16 +: 16] = gen(v.a_base, v.a_col, k);
      if (v.n == 32) exp_b[k*16 +: 16] = gen(v.b_base, v.b_col, k);
    end

    @(negedge clk);
    chk({tag, "_cmd_ready_idle"}, cr[v.sel], 1'b1);
    cmd_op = v.cop;
    cmd_valid[v.sel] = 1'b1;
    @(negedge clk);
    cmd_valid[v.sel] = 1'b0;
    chk({tag, "_accept_to_in_ready"}, ir[v.sel], (v.n > 0));

    loads = 0;
    acc = 0;
    guard = 0;
    while (acc < v.n && guard < 400) begin
      in_valid[v.sel] = 1'b0;
      if (ir[v.sel]) begin
        loads++;
        if (((loads - 1) % (v.gap + 1)) == v.gap) begin
          in_valid[v.sel] = 1'b1;
          in_data = (acc < 16) ? gen(v.a_base, v.a_col, acc) : gen(v.b_base, v.b_col, acc - 16);
          acc++;
        end
      end
      @(negedge clk);
      guard++;
    end
    in_valid[v.sel] = 1'b0;
    chk({tag, "_elements_accepted"}, acc, v.n);
    chk({tag, "_load_cycles"}, loads, v.exp_load);

    // First cycle after the last accepted element (or after a NOP accept).
    chk({tag, "_a0"},  ma_w[v.sel][15:0],    v.exp_a0);
    chk({tag, "_a3"},  ma_w[v.sel][63:48],   v.exp_a3);
    chk({tag, "_a15"}, ma_w[v.sel][255:240], v.exp_a15);
    chk({tag, "_b0"},  mb_w[v.sel][15:0],    v.exp_b0);
    chk({tag, "_b15"}, mb_w[v.sel][255:240], v.exp_b15);
    chk({tag, "_matrix_a"}, ma_w[v.sel], exp_a);
    chk({tag, "_matrix_b"}, mb_w[v.sel], exp_b);

    opc = 0; op_bad = 0; dcnt = 0; done_p = 0; unstable = 0; cr_bad = 0;
    for (int p = 1; p <= idle_at; p++) begin
      in_valid[v.sel] = 1'b1;
      in_data = 16'hDEAD;
      if (op_w[v.sel] != 4'h0) begin
        opc++;
        if (op_w[v.sel] != v.cop || p > exp_opc) op_bad++;
      end
      if (dn[v.sel]) begin
        dcnt++;
        done_p = p;
      end
      if (ma_w[v.sel] !== exp_a || mb_w[v.sel] !== exp_b) unstable++;
      if (p < idle_at && (cr[v.sel] || !bz[v.sel])) cr_bad++;
      if (p == idle_at) begin
        chk({tag, "_busy_after_done"}, bz[v.sel], 1'b0);
        chk({tag, "_cmd_ready_after_done"}, cr[v.sel], 1'b1);
      end
      @(negedge clk);
    end
    for (int p = 0; p < 3; p++) begin
      if (ma_w[v.sel] !== exp_a || mb_w[v.sel] !== exp_b || ir[v.sel]) unstable++;
      @(negedge clk);
    end
    in_valid[v.sel] = 1'b0;
    chk({tag, "_op_cycles"}, opc, exp_opc);
    chk({tag, "_op_bad"}, op_bad, 0);
    chk({tag, "_done_count"}, dcnt, 1);
    chk({tag, "_done_cycle"}, done_p, done_at);
    chk({tag, "_matrix_stable"}, unstable, 0);
    chk({tag, "_busy_cmd_ready"}, cr_bad, 0);
  endtask

  initial begin
    int acc, guard, p, opc, dcnt;
    vecs[0] = '{4'h1, 0, 0, 32, 16'h0000, 1'b0, 16'h0100, 1'b1, 32, 16'h0000, 16'h0003, 16'h000F, 16'h0100, 16'h0103};
    vecs[1] = '{4'h3, 0, 0, 32, 16'h0000, 1'b1, 16'h0000, 1'b1, 32, 16'h0000, 16'h0003, 16'h0003, 16'h0000, 16'h0003};
    vecs[2] = '{4'h5, 0, 0, 16, 16'h0000, 1'b0, 16'h0000, 1'b0, 16, 16'h0000, 16'h0003, 16'h000F, 16'h0000, 16'h0000};
    vecs[3] = '{4'h2, 0, 1, 32, 16'h0010, 1'b0, 16'h0100, 1'b0, 64, 16'h0010, 16'h0013, 16'h001F, 16'h0100, 16'h010F};
    vecs[4] = '{4'h0, 0, 0, 0,  16'h0000, 1'b0, 16'h0000, 1'b0, 0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{4'h4, 1, 2, 32, 16'hA000, 1'b0, 16'h0005, 1'b1, 96, 16'hA000, 16'hA003, 16'hA00F, 16'h0005, 16'h0008};
    vecs[6] = '{4'h5, 1, 0, 16, 16'h0007, 1'b1, 16'h0000, 1'b0, 16, 16'h0007, 16'h000A, 16'h000A, 16'h0000, 16'h0000};

    rst = 1'b1;
    cmd_valid = 2'b00;
    in_valid = 2'b00;
    cmd_op = 4'h0;
    in_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cr, 2'b11);
    chk("reset_in_ready", ir, 2'b00);
    chk("reset_busy", bz, 2'b00);
    chk("reset_done", dn, 2'b00);
    chk("reset_op", {op_w[1], op_w[0]}, 8'h00);
    chk("reset_matrix_a", ma_w[0] | ma_w[1], 256'h0);
    chk("reset_matrix_b", mb_w[0] | mb_w[1], 256'h0);
    rst = 1'b0;

    // Abort after ten A elements; reset wins over simultaneous cmd_valid/in_valid.
    @(negedge clk);
    cmd_op = 4'h1;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = 1'b1;
      in_data = 16'(k + 1);
      @(negedge clk);
    end
    chk("abort_elem9_loaded", ma_w[0][159:144], 16'd10);
    rst = 1'b1;
    cmd_valid[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_valid[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("abort_busy", bz[0], 1'b0);
    chk("abort_cmd_ready", cr[0], 1'b1);
    chk("abort_in_ready", ir[0], 1'b0);
    chk("abort_matrix_a", ma_w[0], 256'h0);
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (dn[0]) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", dcnt, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // ALU_LAT=3 with cmd_valid held high through the whole operation.
    @(negedge clk);
    cmd_op = 4'h3;
    cmd_valid[1] = 1'b1;
    @(negedge clk);
    acc = 0;
    guard = 0;
    while (acc < 32 && guard < 200) begin
      in_valid[1] = 1'b0;
      if (ir[1]) begin
        in_valid[1] = 1'b1;
        in_data = 16'(acc);
        acc++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid[1] = 1'b0;
    chk("hold_elements", acc, 32);
    p = 0;
    opc = 0;
    dcnt = 0;
    while (!cr[1] && p < 10) begin
      p++;
      if (op_w[1] == 4'h3) opc++;
      if (dn[1]) dcnt++;
      @(negedge clk);
    end
    chk("hold_cycles_to_idle", p, 4);
    chk("hold_op_cycles", opc, 3);
    chk("hold_done_count", dcnt, 1);
    chk("hold_b15", mb_w[1][255:240], 16'd31);
    cmd_op = 4'h0;
    @(negedge clk);
    chk("hold_second_accept_done", dn[1], 1'b1);
    chk("hold_second_clear_a", ma_w[1], 256'h0);
    chk("hold_second_op", op_w[1], 4'h0);
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    chk("hold_final_busy", bz[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ALU_LAT, default 1, number of cycles op and operands are presented to the ALU in ISSUE; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset: synchronous and active-high; one clock domain only.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_op  input  4  ALU opcode, same encoding as the ALU (0 NOP, 1 MMULT, 2 MSCALAR, 3 MADD, 4 MSUB, 5 MTRANS, 6..F scalar/compare ops).
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 in_valid  input  1  element data valid.
REQ-008 in_data  input  16  one matrix element, row-major order.
REQ-009 in_ready  output  1  element accepted when in_valid & in_ready.
REQ-010 matrix_a  output  256  operand A; element (i,j) at bits (i*4+j)*16 +: 16.
REQ-011 matrix_b  output  256  operand B; same packing as matrix_a.
REQ-012 op  output  4  opcode to the ALU.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 The block SHALL implement states IDLE, LOAD_A, LOAD_B, ISSUE, DONE with a 4-bit element counter idx and a latched opcode register.
REQ-016 IDLE: cmd_ready=1, in_ready=0; on cmd_valid, latch cmd_op, set idx=0, clear matrix_a and matrix_b to 0, and go to LOAD_A, or to DONE if cmd_op==NOP.
REQ-017 LOAD_A: in_ready=1; each accepted element is written to matrix_a element idx, and idx increments, wrapping from 15 to 0.
REQ-018 After the 16th accepted A element, the block SHALL go to ISSUE if the latched op is MTRANS, else to LOAD_B (idx=0).
REQ-019 LOAD_B: in_ready=1; accepted elements are written to matrix_b element idx; after the 16th element, go to ISSUE.
REQ-020 MTRANS SHALL leave matrix_b all-zero; MSCALAR loads all 16 B elements (the scalar is element (0,0)).
REQ-021 Cycles with in_valid=0 in LOAD states SHALL stall without changing idx or matrix contents.
REQ-022 ISSUE: op = latched opcode for exactly ALU_LAT consecutive cycles (internal down-counter), then go to DONE.
REQ-023 op SHALL be 0 (NOP) in every state other than ISSUE.
REQ-024 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-025 matrix_a and matrix_b SHALL change only on accepted elements or command-accept clear, and SHALL be stable throughout ISSUE and DONE.
REQ-026 After DONE, matrix_a and matrix_b SHALL hold their values until the next command is accepted.
REQ-027 cmd_ready=0 outside IDLE; cmd_valid is ignored while busy; in_data and in_valid are ignored outside LOAD_A and LOAD_B.
REQ-028 Command accept to first in_ready is 1 cycle; the last element accepted to first op-valid cycle is 1 cycle.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL enter IDLE with idx=0, the latched op=0, the ISSUE counter=0, matrix_a=0, matrix_b=0, op=0, done=0, busy=0, in_ready=0, and cmd_ready=1 on the following cycle.
REQ-030 rst asserted during LOAD_A, LOAD_B or ISSUE SHALL abort the operation with no done pulse, and partially loaded data SHALL be cleared.
REQ-031 rst SHALL take priority over any simultaneous cmd_valid or in_valid.

Verification
REQ-032 MADD, ALU_LAT=1, 32 back-to-back elements (A: a[i][j]=j, B: b[i][j]=j) -> matrix_a[15:0]=0, matrix_a[63:48]=3, op=3 for 1 cycle, done 1 cycle later, busy low after.
REQ-033 MTRANS, 16 elements 0..15 -> no LOAD_B (in_ready drops after element 16), matrix_b=0, matrix_a[255:240]=15, op=5 for ALU_LAT cycles.
REQ-034 MSCALAR with in_valid toggling every other cycle, B element 0 = 256 -> matrix_b[15:0]=16'h0100, load takes 64 cycles, no element lost or duplicated.
REQ-035 NOP command -> done on the cycle after accept, op stays 0, matrices cleared to 0.
REQ-036 rst after the 10th A element -> next cycle IDLE, matrix_a=0, no done; a new MMULT command then loads from element 0.
REQ-037 ALU_LAT=3 with cmd_valid held high during ISSUE -> op valid for exactly 3 cycles, second command not accepted until IDLE.
